// File: rtl/pipe_ctrl_if.sv
// Hazard/stall handshake between the pipeline sequencer and the rest of the core:
// hazard requests flow in, per-stage enable/clear strobes flow out.
interface pipe_ctrl_if;
  logic stall;
  logic flush;
  logic mem_busy;
  logic pc_en;
  logic fd_en;
  logic fd_clr;
  logic de_en;
  logic de_clr;
  logic em_en;
  logic mw_en;

  // Hazard unit / memory side: drives requests, observes strobes.
  modport master (
    output stall, flush, mem_busy,
    input  pc_en, fd_en, fd_clr, de_en, de_clr, em_en, mw_en
  );

  // Sequencer side: consumes requests, produces strobes.
  modport slave (
    input  stall, flush, mem_busy,
    output pc_en, fd_en, fd_clr, de_en, de_clr, em_en, mw_en
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: turns stall/flush/mem_busy into per-stage strobes,
// remembers flushes raised during memory waits, runs a freeze watchdog and perf counters.
module pipe_ctrl #(
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_ctrl_if.slave       pipe,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] wait_cycles,
  output logic             wdog_err
);

  localparam int WD_W = $clog2(WDOG_LIMIT);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_WAIT_FL
  } state_t;

  typedef enum logic [1:0] {
    D_RUN,
    D_FREEZE,
    D_FLUSH,
    D_STALL
  } decision_t;

  state_t    state, state_nxt;
  decision_t dec;
  logic      fl_eff;
  logic      frozen;
  logic [WD_W-1:0] wd_cnt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt   = state;
    dec         = D_RUN;
    pipe.pc_en  = 1'b1;
    pipe.fd_en  = 1'b1;
    pipe.fd_clr = 1'b0;
    pipe.de_en  = 1'b1;
    pipe.de_clr = 1'b0;
    pipe.em_en  = 1'b1;
    pipe.mw_en  = 1'b1;

    fl_eff = pipe.flush | (state == S_WAIT_FL);

    if (pipe.mem_busy)  dec = D_FREEZE;
    else if (fl_eff)    dec = D_FLUSH;
    else if (pipe.stall) dec = D_STALL;

    // At most one flush is ever owed; WAIT_FL simply holds until memory is ready.
    unique case (state)
      S_RUN, S_WAIT: begin
        if (pipe.mem_busy) state_nxt = pipe.flush ? S_WAIT_FL : S_WAIT;
        else               state_nxt = S_RUN;
      end
      S_WAIT_FL: state_nxt = pipe.mem_busy ? S_WAIT_FL : S_RUN;
      default:   state_nxt = S_RUN;
    endcase

    unique case (dec)
      D_FREEZE: begin
        pipe.pc_en = 1'b0;
        pipe.fd_en = 1'b0;
        pipe.de_en = 1'b0;
        pipe.em_en = 1'b0;
        pipe.mw_en = 1'b0;
      end
      D_FLUSH: begin
        pipe.fd_clr = 1'b1;
        pipe.de_clr = 1'b1;
      end
      D_STALL: begin
        pipe.pc_en  = 1'b0;
        pipe.fd_en  = 1'b0;
        pipe.de_clr = 1'b1;
      end
      default: ;
    endcase

    // Reset holds the front of the pipe cleared and everything frozen.
    if (!rst_n) begin
      pipe.pc_en  = 1'b0;
      pipe.fd_en  = 1'b0;
      pipe.fd_clr = 1'b1;
      pipe.de_en  = 1'b0;
      pipe.de_clr = 1'b1;
      pipe.em_en  = 1'b0;
      pipe.mw_en  = 1'b0;
    end
  end

  // Only mem_busy or an applied stall hold the PC; a flush always lets it advance.
  assign frozen = (dec == D_FREEZE) || (dec == D_STALL);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (!rst_n) begin
      state        <= S_RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
      wait_cycles  <= '0;
      wd_cnt       <= '0;
      wdog_err     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (dec == D_STALL && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (dec == D_FLUSH && flush_count  != '1) flush_count  <= flush_count  + CNT_W'(1);
      if (dec == D_FREEZE && wait_cycles != '1) wait_cycles  <= wait_cycles  + CNT_W'(1);

      if (frozen) begin
        if (wd_cnt == WD_W'(WDOG_LIMIT - 1)) wdog_err <= 1'b1;
        else                                 wd_cnt   <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle vector table followed by hand-written
// sequences for counter saturation and the freeze watchdog.
module tb_pipe_ctrl;

  localparam int CNT_W      = 4;
  localparam int WDOG_LIMIT = 64;

  // Strobe order: {pc_en, fd_en, fd_clr, de_en, de_clr, em_en, mw_en}
  localparam logic [6:0] ST_RUN = 7'b1101011;
  localparam logic [6:0] ST_FRZ = 7'b0000000;
  localparam logic [6:0] ST_FLS = 7'b1111111;
  localparam logic [6:0] ST_STL = 7'b0001111;
  localparam logic [6:0] ST_RST = 7'b0010100;

  typedef struct {
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic       mem_busy;
    logic [6:0] strb;
    int         s_cnt;
    int         f_cnt;
    int         w_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [CNT_W-1:0] stall_cycles, flush_count, wait_cycles;
  logic wdog_err;

  int total = 0;
  int passed = 0;

  pipe_ctrl_if pif ();

  pipe_ctrl #(.CNT_W(CNT_W), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe         (pif.slave),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .wait_cycles  (wait_cycles),
    .wdog_err     (wdog_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] strobes();
    return {pif.pc_en, pif.fd_en, pif.fd_clr, pif.de_en, pif.de_clr, pif.em_en, pif.mw_en};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else             passed++;
  endtask

  // Drive one cycle's inputs just after the rising edge; callers sample a few ns later.
  task automatic drive(input logic r, input logic s, input logic f, input logic m);
    @(posedge clk);
    #1;
    rst_n        = r;
    pif.stall    = s;
    pif.flush    = f;
    pif.mem_busy = m;
    #3;
  endtask

  vec_t vq[$];

  initial begin
    rst_n        = 1'b0;
    pif.stall    = 1'b0;
    pif.flush    = 1'b0;
    pif.mem_busy = 1'b0;
    repeat (2) @(posedge clk);

    //            rst   stl   fl    mb    strobes  s  f  w  (counters seen before this row's edge)
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, ST_RST, 0, 0, 0});
    for (int i = 0; i < 5; i++)
      vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 0, 0, 0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, ST_STL, 0, 0, 0});  // load-use bubble
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 1, 0, 0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, ST_FRZ, 1, 0, 0});  // 4-cycle wait, flush in 2nd
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, ST_FRZ, 1, 0, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, ST_FRZ, 1, 0, 2});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, ST_FRZ, 1, 0, 3});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_FLS, 1, 0, 4});  // owed flush applied
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 1, 1, 4});
    vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, ST_FLS, 1, 1, 4});  // flush beats stall
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 1, 2, 4});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, ST_FRZ, 1, 2, 4});  // mem_busy falls as flush rises
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, ST_FLS, 1, 2, 5});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 1, 3, 5});
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, ST_FRZ, 1, 3, 5});  // second flush in WAIT_FL not queued
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, ST_FRZ, 1, 3, 6});
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, ST_FLS, 1, 3, 7});  // owed + live flush = one event
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 1, 4, 7});
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b1, ST_FRZ, 1, 4, 7});  // stall ignored under mem_busy
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, ST_STL, 1, 4, 8});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 2, 4, 8});
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, ST_FRZ, 2, 4, 8});  // reset mid-wait drops owed flush
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, ST_RST, 2, 4, 9});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 0, 0, 0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN, 0, 0, 0});

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].stall, vq[i].flush, vq[i].mem_busy);
      check($sformatf("row%0d strobes", i), 32'(strobes()), 32'(vq[i].strb));
      if (i > 0) begin
        check($sformatf("row%0d stall_cycles", i), 32'(stall_cycles), vq[i].s_cnt);
        check($sformatf("row%0d flush_count", i), 32'(flush_count), vq[i].f_cnt);
        check($sformatf("row%0d wait_cycles", i), 32'(wait_cycles), vq[i].w_cnt);
        check($sformatf("row%0d wdog_err", i), 32'(wdog_err), 32'd0);
      end
    end

    // Stall counter saturates at 2^CNT_W-1.
    repeat (20) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("stall_sat", 32'(stall_cycles), 32'd15);
    check("wdog_after_20_stalls", 32'(wdog_err), 32'd0);

    // Watchdog is cleared by any advancing cycle.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (40) drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("wdog_broken_run", 32'(wdog_err), 32'd0);
    check("wait_sat", 32'(wait_cycles), 32'd15);

    // Watchdog fires on the edge ending the 64th consecutive frozen cycle.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (63) drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("wdog_after_63", 32'(wdog_err), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("wdog_after_64", 32'(wdog_err), 32'd1);
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("wdog_sticky", 32'(wdog_err), 32'd1);
    check("strobes_after_wdog", 32'(strobes()), 32'(ST_RUN));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("wdog_cleared_by_reset", 32'(wdog_err), 32'd0);
    check("wait_cleared_by_reset", 32'(wait_cycles), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
